// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command decoder: opcodes, FSM encoding,
// status-byte layout and a helper that assembles the status byte.
package spi_cmd_pkg;

   localparam logic [7:0] OP_CTRL   = 8'h01;
   localparam logic [7:0] OP_CLEAR  = 8'h02;
   localparam logic [7:0] OP_RDCNT  = 8'h03;
   localparam logic [7:0] OP_RDSTAT = 8'h04;

   typedef enum logic {
      IDLE = 1'b0,
      ARG  = 1'b1
   } state_e;

   localparam int unsigned STAT_CET = 0;
   localparam int unsigned STAT_CEP = 1;
   localparam int unsigned STAT_TC  = 2;
   localparam int unsigned STAT_ERR = 7;

   function automatic logic [7:0] status_byte(input logic err, input logic tc_flag,
                                              input logic cep, input logic cet);
      logic [7:0] s;
      s           = '0;
      s[STAT_ERR] = err;
      s[STAT_TC]  = tc_flag;
      s[STAT_CEP] = cep;
      s[STAT_CET] = cet;
      return s;
   endfunction

endpackage

// File: rtl/spi_cmd_regs_ce0_sync.sv
// Brings the raw SPI chip enable into the clock domain and emits a one-cycle
// strobe (bstb) on its rising edge, i.e. when an SPI byte has completed.
module ce0_sync (
   input  logic clock,
   input  logic rst,
   input  logic ce0,
   output logic bstb
);

   logic sync1_q, sync2_q, ce0_dly_q;
   logic sync1_d, sync2_d, ce0_dly_d;

   always_comb begin
      sync1_d   = ce0;
      sync2_d   = sync1_q;
      ce0_dly_d = sync2_q;
   end

   // NOTE: all three flops reset to 1 (ce0 idle level) so that leaving reset
   // can never look like a rising edge and fire a spurious strobe.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         ce0_dly_q <= 1'b1;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         ce0_dly_q <= ce0_dly_d;
      end
   end

   assign bstb = sync2_q & ~ce0_dly_q;

endmodule

// File: rtl/spi_cmd_regs.sv
// SPI command decoder driving the event counter's enable/clear inputs and
// loading tx_byte with count or status. Option macro: SPI_CMD_TIMEOUT_EN.
module spi_cmd_regs #(
   parameter int unsigned SIZE    = 5,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic            clock,
   input  logic            rst,
   input  logic            ce0,
   input  logic [7:0]      rx_byte,
   output logic [7:0]      tx_byte,
   input  logic [SIZE-1:0] count,
   input  logic            tc,
   output logic            cnt_cet,
   output logic            cnt_cep,
   output logic            cnt_rst
);

   import spi_cmd_pkg::*;

   if (SIZE > 8 || SIZE < 1 || TIMEOUT < 2) begin : g_bad_params
      $error("spi_cmd_regs: SIZE must be 1..8 and TIMEOUT must be >= 2");
   end

   logic   bstb;
   state_e state_q, state_d;
   logic [7:0] tx_byte_q, tx_byte_d;
   logic   cnt_cet_q, cnt_cet_d;
   logic   cnt_cep_q, cnt_cep_d;
   logic   cnt_rst_q, cnt_rst_d;
   logic   tc_flag_q, tc_flag_d;
   logic   err_flag_q, err_flag_d;
   logic   err_bit;

   ce0_sync u_ce0_sync (
      .clock (clock),
      .rst   (rst),
      .ce0   (ce0),
      .bstb  (bstb)
   );

`ifdef SPI_CMD_TIMEOUT_EN
   localparam int unsigned TIMER_W = $clog2(TIMEOUT);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

   logic [TIMER_W-1:0] timer_q, timer_d;

   assign err_bit = err_flag_q;
`else
   assign err_bit = 1'b0;
`endif

   // NOTE: every variable gets its hold/idle value first, so no path through
   // the case statements can leave one unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      tx_byte_d  = tx_byte_q;
      cnt_cet_d  = cnt_cet_q;
      cnt_cep_d  = cnt_cep_q;
      cnt_rst_d  = 1'b0;
      tc_flag_d  = tc_flag_q;
      err_flag_d = err_flag_q;
`ifdef SPI_CMD_TIMEOUT_EN
      timer_d    = '0;
`endif

      case (state_q)
         IDLE: begin
            if (bstb) begin
               case (rx_byte)
                  OP_CTRL:   state_d = ARG;
                  OP_CLEAR:  cnt_rst_d = 1'b1;
                  OP_RDCNT:  tx_byte_d = 8'(count);
                  OP_RDSTAT: begin
                     tx_byte_d = status_byte(err_bit, tc_flag_q, cnt_cep_q, cnt_cet_q);
                     tc_flag_d = 1'b0;
                  end
                  default:   err_flag_d = 1'b1;
               endcase
            end
         end
         ARG: begin
            if (bstb) begin
               cnt_cet_d = rx_byte[0];
               cnt_cep_d = rx_byte[1];
               state_d   = IDLE;
            end
`ifdef SPI_CMD_TIMEOUT_EN
            else if (timer_q == TIMER_LAST) begin
               state_d    = IDLE;
               err_flag_d = 1'b1;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
`endif
         end
      endcase

      // A live tc beats the RDSTAT clear; a CLEAR beats tc since tc is stale.
      if (tc) begin
         tc_flag_d = 1'b1;
      end
      if (cnt_rst_d) begin
         tc_flag_d  = 1'b0;
         err_flag_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples its _d value from before the edge regardless of statement order.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         tx_byte_q  <= 8'h00;
         cnt_cet_q  <= 1'b0;
         cnt_cep_q  <= 1'b0;
         cnt_rst_q  <= 1'b0;
         tc_flag_q  <= 1'b0;
         err_flag_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_byte_q  <= tx_byte_d;
         cnt_cet_q  <= cnt_cet_d;
         cnt_cep_q  <= cnt_cep_d;
         cnt_rst_q  <= cnt_rst_d;
         tc_flag_q  <= tc_flag_d;
         err_flag_q <= err_flag_d;
      end
   end

`ifdef SPI_CMD_TIMEOUT_EN
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end
`endif

   assign tx_byte = tx_byte_q;
   assign cnt_cet = cnt_cet_q;
   assign cnt_cep = cnt_cep_q;
   assign cnt_rst = cnt_rst_q;

endmodule

// File: tb/tb_spi_cmd_regs.sv
// Self-checking bench for spi_cmd_regs: directed vector table, multi-cycle
// corner sequences, then random bytes against a protocol-level model.
module tb_spi_cmd_regs;

   localparam int SIZE    = 5;
   localparam int TIMEOUT = 16;

`ifdef SPI_CMD_TIMEOUT_EN
   localparam bit         TO_EN   = 1'b1;
   localparam logic [7:0] ERR_BIT = 8'h80;
`else
   localparam bit         TO_EN   = 1'b0;
   localparam logic [7:0] ERR_BIT = 8'h00;
`endif

   logic            clock   = 1'b0;
   logic            rst     = 1'b1;
   logic            ce0     = 1'b1;
   logic [7:0]      rx_byte = 8'h00;
   logic [SIZE-1:0] count   = '0;
   logic            tc      = 1'b0;
   logic [7:0]      tx_byte;
   logic            cnt_cet, cnt_cep, cnt_rst;

   spi_cmd_regs #(.SIZE(SIZE), .TIMEOUT(TIMEOUT)) dut (
      .clock   (clock),
      .rst     (rst),
      .ce0     (ce0),
      .rx_byte (rx_byte),
      .tx_byte (tx_byte),
      .count   (count),
      .tc      (tc),
      .cnt_cet (cnt_cet),
      .cnt_cep (cnt_cep),
      .cnt_rst (cnt_rst)
   );

   always #5 clock = ~clock;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%02h, expected 0x%02h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Protocol-level reference model
   bit         m_arg, m_cet, m_cep, m_tc, m_err, m_rst;
   logic [7:0] m_tx;

   task automatic model_reset();
      m_arg = 0; m_cet = 0; m_cep = 0; m_tc = 0; m_err = 0; m_rst = 0;
      m_tx  = 8'h00;
   endtask

   task automatic model_byte(input logic [7:0] b, input logic [SIZE-1:0] cnt, input bit tc_co);
      m_rst = 0;
      if (m_arg) begin
         m_cet = b[0];
         m_cep = b[1];
         m_arg = 0;
         if (tc_co) m_tc = 1;
      end else begin
         case (b)
            8'h01: m_arg = 1;
            8'h02: begin m_rst = 1; m_tc = 0; m_err = 0; end
            8'h03: m_tx = 8'(cnt);
            8'h04: begin
               m_tx = (m_err ? ERR_BIT : 8'h00) | {5'b0, m_tc, m_cep, m_cet};
               m_tc = 0;
            end
            default: m_err = 1;
         endcase
         if (tc_co && b != 8'h02) m_tc = 1;
      end
   endtask

   task automatic model_idle(input int n);
      if (TO_EN && m_arg && n >= TIMEOUT) begin
         m_arg = 0;
         m_err = 1;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
      model_idle(n);
   endtask

   // One SPI byte: ce0 low, rx_byte set, ce0 rises; strobe lands before the
   // third edge after the rise. Checks latency and the cnt_rst pulse width.
   task automatic send(input logic [7:0] b, input logic [SIZE-1:0] cnt,
                       input bit tc_pre, input bit tc_co, output logic rst_seen);
      logic [7:0] tx_before;
      @(negedge clock);
      if (tc_pre) begin
         tc = 1'b1;
         @(negedge clock);
         tc   = 1'b0;
         m_tc = 1;
      end
      ce0     = 1'b0;
      rx_byte = b;
      count   = cnt;
      repeat (2) @(negedge clock);
      ce0       = 1'b1;
      tx_before = m_tx;
      repeat (2) @(negedge clock);
      check("tx_before_edge3", tx_byte, tx_before);
      check("cnt_rst_before_edge3", {7'b0, cnt_rst}, 8'h00);
      if (tc_co) tc = 1'b1;
      @(negedge clock);
      tc = 1'b0;
      model_byte(b, cnt, tc_co);
      rst_seen = cnt_rst;
      check("cnt_rst_at_edge3", {7'b0, cnt_rst}, {7'b0, m_rst});
      @(negedge clock);
      check("cnt_rst_one_cycle", {7'b0, cnt_rst}, 8'h00);
      repeat (2) @(negedge clock);
   endtask

   typedef struct {
      logic [7:0]      rx;
      logic [SIZE-1:0] cnt;
      bit              tc_pre;
      bit              tc_co;
      logic [7:0]      exp_tx;
      bit              exp_cet;
      bit              exp_cep;
      bit              exp_rst;
   } vec_t;

   vec_t tbl[22];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       rs;
      logic [7:0] b;
      int         sel;

      // rx_byte/count set so a spurious strobe at reset release would be visible
      rx_byte = 8'h03;
      count   = 5'd17;
      model_reset();
      repeat (3) @(negedge clock);
      check("reset_tx", tx_byte, 8'h00);
      check("reset_ctl", {5'b0, cnt_rst, cnt_cep, cnt_cet}, 8'h00);
      rst = 1'b0;
      repeat (5) begin
         @(negedge clock);
         check("no_strobe_tx", tx_byte, 8'h00);
         check("no_strobe_rst", {7'b0, cnt_rst}, 8'h00);
      end

      //          rx     cnt    pre co  exp_tx           cet cep rst
      tbl[0]  = '{8'h03, 5'd17, 0,  0,  8'h11,            0,  0,  0};
      tbl[1]  = '{8'h01, 5'd17, 0,  0,  8'h11,            0,  0,  0};
      tbl[2]  = '{8'h03, 5'd17, 0,  0,  8'h11,            1,  1,  0};
      tbl[3]  = '{8'h04, 5'd17, 0,  0,  8'h03,            1,  1,  0};
      tbl[4]  = '{8'h04, 5'd17, 1,  0,  8'h07,            1,  1,  0};
      tbl[5]  = '{8'h04, 5'd17, 0,  0,  8'h03,            1,  1,  0};
      tbl[6]  = '{8'h04, 5'd17, 0,  1,  8'h03,            1,  1,  0};
      tbl[7]  = '{8'h04, 5'd17, 0,  0,  8'h07,            1,  1,  0};
      tbl[8]  = '{8'h55, 5'd17, 0,  0,  8'h07,            1,  1,  0};
      tbl[9]  = '{8'h04, 5'd17, 0,  0,  8'h03 | ERR_BIT,  1,  1,  0};
      tbl[10] = '{8'h02, 5'd17, 0,  0,  8'h03 | ERR_BIT,  1,  1,  1};
      tbl[11] = '{8'h04, 5'd17, 0,  0,  8'h03,            1,  1,  0};
      tbl[12] = '{8'h02, 5'd17, 0,  1,  8'h03,            1,  1,  1};
      tbl[13] = '{8'h04, 5'd17, 0,  0,  8'h03,            1,  1,  0};
      tbl[14] = '{8'h01, 5'd17, 0,  0,  8'h03,            1,  1,  0};
      tbl[15] = '{8'h02, 5'd17, 0,  0,  8'h03,            0,  1,  0};
      tbl[16] = '{8'h04, 5'd17, 0,  0,  8'h02,            0,  1,  0};
      tbl[17] = '{8'h01, 5'd17, 0,  0,  8'h02,            0,  1,  0};
      tbl[18] = '{8'hFD, 5'd17, 0,  0,  8'h02,            1,  0,  0};
      tbl[19] = '{8'h04, 5'd17, 0,  0,  8'h01,            1,  0,  0};
      tbl[20] = '{8'h03, 5'd31, 0,  0,  8'h1F,            1,  0,  0};
      tbl[21] = '{8'h03, 5'd0,  0,  0,  8'h00,            1,  0,  0};

      foreach (tbl[i]) begin
         send(tbl[i].rx, tbl[i].cnt, tbl[i].tc_pre, tbl[i].tc_co, rs);
         check($sformatf("tbl%0d_tx", i), tx_byte, tbl[i].exp_tx);
         check($sformatf("tbl%0d_cet_cep", i), {6'b0, cnt_cep, cnt_cet},
               {6'b0, tbl[i].exp_cep, tbl[i].exp_cet});
         check($sformatf("tbl%0d_rst", i), {7'b0, rs}, {7'b0, tbl[i].exp_rst});
      end

      // CTRL followed by a long silence, then RDSTAT twice
      send(8'h01, 5'd3, 0, 0, rs);
      idle(20);
      send(8'h04, 5'd3, 0, 0, rs);
      check("timeout_tx", tx_byte, m_tx);
      check("timeout_ctl", {6'b0, cnt_cep, cnt_cet}, {6'b0, m_cep, m_cet});
      send(8'h04, 5'd3, 0, 0, rs);
      check("timeout_tx2", tx_byte, m_tx);

      // Reset while a CTRL argument is pending
      send(8'h01, 5'd3, 0, 0, rs);
      send(8'h03, 5'd3, 0, 0, rs);
      send(8'h03, 5'd22, 0, 0, rs);
      send(8'h01, 5'd3, 0, 0, rs);
      @(negedge clock);
      rst = 1'b1;
      #1;
      check("midreset_tx", tx_byte, 8'h00);
      check("midreset_ctl", {5'b0, cnt_rst, cnt_cep, cnt_cet}, 8'h00);
      repeat (2) @(negedge clock);
      rst = 1'b0;
      model_reset();
      send(8'h03, 5'd9, 0, 0, rs);
      check("post_reset_opcode_tx", tx_byte, 8'h09);
      check("post_reset_ctl", {6'b0, cnt_cep, cnt_cet}, 8'h00);

      // Random traffic against the model
      for (int k = 0; k < 60; k++) begin
         sel = $urandom_range(0, 5);
         if (m_arg)         b = 8'($urandom);
         else if (sel < 4)  b = 8'(sel + 1);
         else if (sel == 4) b = 8'($urandom);
         else               b = 8'h02;
         send(b, SIZE'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), rs);
         check($sformatf("rnd%0d_tx(op %02h)", k, b), tx_byte, m_tx);
         check($sformatf("rnd%0d_ctl", k), {6'b0, cnt_cep, cnt_cet}, {6'b0, m_cep, m_cet});
         idle($urandom_range(0, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
